xibus_master_seq: RTL and testbench
===================================

# xibus_master_seq

Bus-cycle sequencer for the XiBus CPU master port. Accepts one CPU access at a time, latches it, and drives the `cpu_encoder` inputs (`adrcy`, `cpu_write`, `cpu_addr`, `cpu_wdata`) through an address phase and a data phase. It then waits for the target's ready and returns a single-cycle acknowledge, with read data or error, to the CPU. It sits between the CPU core and `cpu_encoder`, and owns the bus strobes and the AD output enable.

## Interface
- `TO_CYCLES`, 255: maximum data-phase wait cycles before a timeout; used only with `XIBUS_TIMEOUT_EN`; range 1..65535.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: access request; held high with stable attributes until `cpu_ack`.
- `cpu_write` in 4: byte write strobes; 0000 = read word.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_err` out 1: valid with `cpu_ack`; set on illegal strobe or timeout.
- `cpu_rdata` out 32: read data, valid with `cpu_ack`.
- `cpu_busy` out 1: high in every state except IDLE.
- `enc_adrcy` out 1: to encoder `adrcy`.
- `enc_write` out 4: latched strobes, to encoder.
- `enc_addr` out 32: latched address, to encoder.
- `enc_wdata` out 32: latched write data, to encoder.
- `enc_error_i` in 1: encoder `error_o`.
- `as_n` out 1: address strobe, active low.
- `ds_n` out 1: data strobe, active low.
- `ad_oe` out 1: AD pad output enable.
- `ad_i` in 32: AD pad input, used for read data.
- `rdyn_i` in 1: target ready, active low; synchronous to `clk`.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - All strobes are inactive.
  - When `cpu_req`=1 is sampled, latch `cpu_write`, `cpu_addr` and `cpu_wdata` into the `enc_*` registers and go to ADDR.
- **ADDR** (exactly one cycle)
  - `enc_adrcy`=1 and `ad_oe`=1.
  - If `enc_error_i`=1: `as_n` stays 1, no bus cycle is issued, set the error flag, go to RESP.
  - Otherwise: `as_n`=0, go to DATA.
- **DATA**
  - `enc_adrcy`=0, `as_n`=0 and `ds_n`=0.
  - `ad_oe`=1 for writes (`enc_write`≠0) and 0 for reads.
  - On sampled `rdyn_i`=0: capture `ad_i` into `cpu_rdata` for reads (write leaves `cpu_rdata`=0), then go to RESP.
- **RESP** (one cycle)
  - `cpu_ack`=1 and `cpu_err`=error flag; all strobes inactive.
  - Go to IDLE. A new request can be sampled in the following IDLE cycle.
- `cpu_req` is sampled only in IDLE. Deasserting it mid-access does not abort the access: the cycle completes and `cpu_ack` is still issued.
- The `enc_*` registers hold their values from latch until the next latch, so encoder inputs stay stable across ADDR and DATA.
- The error flag clears on entry to ADDR.
- `cpu_rdata` holds its value until the next capture. It is forced to 0 on error.

## Timing
- Reset values:
  - `as_n`=`ds_n`=1.
  - `cpu_ack`=`cpu_err`=`cpu_busy`=`enc_adrcy`=`ad_oe`=0.
  - `enc_write`=0, `enc_addr`=0, `enc_wdata`=0, `cpu_rdata`=0.
  - State is IDLE.
- Latency:
  - Request sampled at edge E0 → ADDR in cycle E0..E1 → DATA from E1.
  - With `rdyn_i`=0 at E2, `cpu_ack` is high during E2..E3.
  - Minimum request-to-ack is 3 cycles; each wait cycle adds 1.
- Illegal strobe: `cpu_ack`/`cpu_err` are high during E1..E2 (2 cycles), and `as_n` never asserts.
- `rdyn_i` low outside DATA is ignored.
- Reset asserted mid-access: all outputs return to reset values immediately (asynchronously), no `cpu_ack` is issued, and the access is lost.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `XIBUS_TIMEOUT_EN` defined:
  - A 16-bit wait counter clears on entry to DATA and increments each DATA cycle with `rdyn_i`=1.
  - When the count reaches `TO_CYCLES`, go to RESP with `cpu_err`=1 and `cpu_rdata`=0.
  - `rdyn_i`=0 on the same edge as the count reaching `TO_CYCLES` wins: normal completion, no error.
- `XIBUS_TIMEOUT_EN` undefined: no counter; DATA waits indefinitely for `rdyn_i`=0.

## Test plan
- Write word: `cpu_write`=1111, addr 0x0000_1000, wdata 0xDEADBEEF, `rdyn_i` held 0 → `enc_adrcy` 1 for one cycle, then `ad_oe`=1 and `ds_n`=0 for one cycle; `cpu_ack`=1, `cpu_err`=0 exactly 3 cycles after the request edge.
- Read with 4 wait states: `cpu_write`=0000, `ad_i`=0x1234_5678 once `rdyn_i` goes 0 after 4 DATA cycles → `ad_oe`=0 in DATA; `cpu_rdata`=0x1234_5678 with `cpu_ack` at cycle 7.
- Illegal strobe: `cpu_write`=0101 (encoder `error_o`=1) → `as_n` stays 1; `cpu_ack`=`cpu_err`=1 at cycle 2; `cpu_rdata`=0.
- Timeout (`XIBUS_TIMEOUT_EN`, `TO_CYCLES`=8), `rdyn_i` stuck 1 → `cpu_err`=1 after 8 DATA cycles. Repeat with `rdyn_i`=0 on the 8th cycle → `cpu_err`=0.
- Back-to-back: `cpu_req` held high across two accesses → second ADDR starts one cycle after the first `cpu_ack`. Dropping `cpu_req` in DATA still yields `cpu_ack`.
- Reset mid-DATA: `rst_n` pulsed low → `ds_n`/`as_n` go 1 and `cpu_busy` goes 0 without waiting for a clock edge; no `cpu_ack` follows.

Source files
------------

// File: rtl/xibus_master_seq.sv
// XiBus CPU master-port bus-cycle sequencer: IDLE -> ADDR -> DATA -> RESP, all outputs registered.
// Optional data-phase timeout is built when XIBUS_TIMEOUT_EN is defined.
module xibus_master_seq #(
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        cpu_busy,
  output logic        enc_adrcy,
  output logic [3:0]  enc_write,
  output logic [31:0] enc_addr,
  output logic [31:0] enc_wdata,
  input  logic        enc_error_i,
  output logic        as_n,
  output logic        ds_n,
  output logic        ad_oe,
  input  logic [31:0] ad_i,
  input  logic        rdyn_i
);

  localparam int unsigned CNT_W = 16;

  if (TO_CYCLES == 0 || TO_CYCLES > 65535) begin : g_to_range
    $error("xibus_master_seq: TO_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [3:0]  enc_write_q, enc_write_d;
  logic [31:0] enc_addr_q, enc_addr_d;
  logic [31:0] enc_wdata_q, enc_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic ack_q, ack_d;
  logic cerr_q, cerr_d;
  logic busy_q, busy_d;
  logic adrcy_q, adrcy_d;
  logic as_n_q, as_n_d;
  logic ds_n_q, ds_n_d;
  logic ad_oe_q, ad_oe_d;

`ifdef XIBUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus latched request, error flag and read-data capture
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    enc_write_d = enc_write_q;
    enc_addr_d  = enc_addr_q;
    enc_wdata_d = enc_wdata_q;
    rdata_d     = rdata_q;
`ifdef XIBUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          enc_write_d = cpu_write;
          enc_addr_d  = cpu_addr;
          enc_wdata_d = cpu_wdata;
          err_d       = 1'b0;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (enc_error_i) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          state_d = S_DATA;
`ifdef XIBUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_DATA: begin
        // Ready takes priority over a timeout on the same edge
        if (!rdyn_i) begin
          rdata_d = (enc_write_q == 4'd0) ? ad_i : 32'd0;
          state_d = S_RESP;
        end else begin
`ifdef XIBUS_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TO_CYCLES)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    ack_d   = (state_d == S_RESP);
    cerr_d  = (state_d == S_RESP) && err_d;
    busy_d  = (state_d != S_IDLE);
    adrcy_d = (state_d == S_ADDR);
    as_n_d  = (state_d != S_DATA);
    ds_n_d  = (state_d != S_DATA);
    ad_oe_d = (state_d == S_ADDR) || ((state_d == S_DATA) && (enc_write_d != 4'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      enc_write_q <= '0;
      enc_addr_q  <= '0;
      enc_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      cerr_q      <= 1'b0;
      busy_q      <= 1'b0;
      adrcy_q     <= 1'b0;
      as_n_q      <= 1'b1;
      ds_n_q      <= 1'b1;
      ad_oe_q     <= 1'b0;
    end else begin
      err_q       <= err_d;
      enc_write_q <= enc_write_d;
      enc_addr_q  <= enc_addr_d;
      enc_wdata_q <= enc_wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      cerr_q      <= cerr_d;
      busy_q      <= busy_d;
      adrcy_q     <= adrcy_d;
      as_n_q      <= as_n_d;
      ds_n_q      <= ds_n_d;
      ad_oe_q     <= ad_oe_d;
    end
  end

  assign cpu_ack   = ack_q;
  assign cpu_err   = cerr_q;
  assign cpu_rdata = rdata_q;
  assign cpu_busy  = busy_q;
  assign enc_adrcy = adrcy_q;
  assign enc_write = enc_write_q;
  assign enc_addr  = enc_addr_q;
  assign enc_wdata = enc_wdata_q;
  assign as_n      = as_n_q;
  assign ds_n      = ds_n_q;
  assign ad_oe     = ad_oe_q;

endmodule

// File: tb/tb_xibus_master_seq.sv
// Directed self-checking bench for xibus_master_seq; timeout vectors run when XIBUS_TIMEOUT_EN is defined.
module tb_xibus_master_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [3:0]  cpu_write;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_err, cpu_busy;
  logic [31:0] cpu_rdata;
  logic        enc_adrcy;
  logic [3:0]  enc_write;
  logic [31:0] enc_addr, enc_wdata;
  logic        enc_err;
  logic        as_n, ds_n, ad_oe;
  logic [31:0] ad_i;
  logic        rdyn_i;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Encoder model: only aligned byte, halfword and word strobe patterns are legal
  function automatic logic strobe_bad(input logic [3:0] w);
    case (w)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b0;
      default:                   return 1'b1;
    endcase
  endfunction

  assign enc_err = strobe_bad(enc_write);

  xibus_master_seq #(.TO_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .enc_adrcy(enc_adrcy), .enc_write(enc_write), .enc_addr(enc_addr), .enc_wdata(enc_wdata),
    .enc_error_i(enc_err), .as_n(as_n), .ds_n(ds_n), .ad_oe(ad_oe),
    .ad_i(ad_i), .rdyn_i(rdyn_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access starting at a negedge; window index c covers posedge E(c-1)..E(c).
  task automatic access(input string tag, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd,
                        input logic pre_rdyn, input logic hold, input logic drop,
                        input int exp_adr, input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_rd, input logic exp_as);
    int   adr_at = 0, lat = 0, ndata = 0, oe_bad = 0;
    logic as_seen = 1'b0, acked = 1'b0, err_s = 1'b0;
    logic [31:0] rd_s = '0;
    cpu_req = 1'b1; cpu_write = we; cpu_addr = a; cpu_wdata = wd;
    rdyn_i = pre_rdyn; ad_i = 32'hBAD0_0000;
    for (int c = 1; c <= 40 && !acked; c++) begin
      @(negedge clk);
      if (enc_adrcy && adr_at == 0) adr_at = c;
      if (!as_n) as_seen = 1'b1;
      if (!ds_n) begin
        ndata++;
        if (ad_oe !== (we != 4'd0)) oe_bad++;
        if (drop) cpu_req = 1'b0;
        rdyn_i = (ndata > waits) ? 1'b0 : 1'b1;
        ad_i   = (ndata > waits) ? rd : 32'hBAD0_0000;
      end
      if (cpu_ack) begin
        acked = 1'b1; lat = c; err_s = cpu_err; rd_s = cpu_rdata;
      end
    end
    chk({tag, "/adrcy_at"}, 32'(adr_at), 32'(exp_adr));
    chk({tag, "/ack_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/err"}, {31'd0, err_s}, {31'd0, exp_err});
    chk({tag, "/rdata"}, rd_s, exp_rd);
    chk({tag, "/as_asserted"}, {31'd0, as_seen}, {31'd0, exp_as});
    chk({tag, "/ad_oe_bad"}, 32'(oe_bad), 32'd0);
    chk({tag, "/enc_addr"}, enc_addr, a);
    chk({tag, "/enc_wdata"}, enc_wdata, wd);
    if (!hold) cpu_req = 1'b0;
    rdyn_i = 1'b1;
  endtask

  initial begin
    int acks;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_write = '0; cpu_addr = '0; cpu_wdata = '0;
    ad_i = '0; rdyn_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst/as_n", {31'd0, as_n}, 32'd1);
    chk("rst/ds_n", {31'd0, ds_n}, 32'd1);
    chk("rst/busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst/ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst/ad_oe", {31'd0, ad_oe}, 32'd0);
    chk("rst/enc_addr", enc_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    access("wr_word", 4'b1111, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0, 1'b1, 1'b0, 1'b0,
           1, 3, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("wr_word/ack_pulse", {31'd0, cpu_ack}, 32'd0);
    chk("wr_word/idle_busy", {31'd0, cpu_busy}, 32'd0);

    access("rd_4ws", 4'b0000, 32'h0000_2000, 32'h0, 4, 32'h1234_5678, 1'b1, 1'b0, 1'b0,
           1, 7, 1'b0, 32'h1234_5678, 1'b1);
    @(negedge clk);
    chk("rd_4ws/rdata_hold", cpu_rdata, 32'h1234_5678);

    access("illegal", 4'b0101, 32'h0000_3000, 32'h5555_AAAA, 0, 32'h0, 1'b1, 1'b0, 1'b0,
           1, 2, 1'b1, 32'h0, 1'b0);
    @(negedge clk);

    // Early ready before DATA must be ignored
    access("rd_early_rdy", 4'b0000, 32'h0000_4000, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0,
           1, 5, 1'b0, 32'hCAFE_F00D, 1'b1);
    @(negedge clk);

    access("b2b_a", 4'b0011, 32'h0000_5000, 32'h0000_BEEF, 0, 32'h0, 1'b1, 1'b1, 1'b0,
           1, 3, 1'b0, 32'h0, 1'b1);
    access("b2b_b", 4'b0000, 32'h0000_5004, 32'h0, 1, 32'hA5A5_5A5A, 1'b1, 1'b0, 1'b0,
           2, 5, 1'b0, 32'hA5A5_5A5A, 1'b1);
    @(negedge clk);

    access("drop_req", 4'b1000, 32'h0000_6000, 32'h7700_0000, 2, 32'h0, 1'b1, 1'b0, 1'b1,
           1, 5, 1'b0, 32'h0, 1'b1);
    @(negedge clk);

`ifdef XIBUS_TIMEOUT_EN
    access("timeout", 4'b0000, 32'h0000_7000, 32'h0, 100, 32'h1111_1111, 1'b1, 1'b0, 1'b0,
           1, 10, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    access("rdy_at_limit", 4'b0000, 32'h0000_7004, 32'h0, 7, 32'h2222_2222, 1'b1, 1'b0, 1'b0,
           1, 10, 1'b0, 32'h2222_2222, 1'b1);
    @(negedge clk);
`endif

    // Asynchronous reset in the middle of DATA
    cpu_req = 1'b1; cpu_write = 4'b0000; cpu_addr = 32'h0000_8000; rdyn_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid/in_data", {31'd0, ds_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid/ds_n", {31'd0, ds_n}, 32'd1);
    chk("rst_mid/as_n", {31'd0, as_n}, 32'd1);
    chk("rst_mid/busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst_mid/enc_addr", enc_addr, 32'd0);
    cpu_req = 1'b0; rdyn_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("rst_mid/no_ack", 32'(acks), 32'd0);
    rdyn_i = 1'b1;

    access("post_rst", 4'b1100, 32'h0000_9000, 32'h1234_0000, 0, 32'h0, 1'b1, 1'b0, 1'b0,
           1, 3, 1'b0, 32'h0, 1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
